rob_alloc_ctrl: RTL

//  Registered re-order-buffer allocator, successor to the combinational queued-count logic. Grants up to

---
 rtl/nvio3_rob_pkg.sv | 18 +
 rtl/rob_range_mask.sv | 18 +
 rtl/rob_alloc_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/nvio3_rob_pkg.sv
// nvio3_rob_pkg: shared ROB allocator widths, IQ state encodings and ring-pointer helpers
package nvio3_rob_pkg;
    localparam int QENTRIES_DEF = 8;
    localparam int RENTRIES_DEF = 16;
    localparam int QBW = $clog2(QENTRIES_DEF);
    localparam int RBW = $clog2(RENTRIES_DEF);
    typedef enum logic [2:0] {
        IQS_INVALID = 3'd0,
        IQS_QUEUE   = 3'd1,
        IQS_OUT     = 3'd2,
        IQS_DONE    = 3'd3
    } iq_state_e;
    typedef logic [RBW-1:0] rid_t;
    typedef logic [RBW:0]   rcnt_t;
    function automatic rid_t rid_add(rid_t r, int n);
        return r + rid_t'(n);
    endfunction
endpackage

// File: rtl/rob_range_mask.sv
// rob_range_mask: ring mask and entry count of ROB slots in [lo..hi), empty when lo==hi
module rob_range_mask
    import nvio3_rob_pkg::*;
#(
    parameter int N = RENTRIES_DEF
) (
    input  rid_t         lo,
    input  rid_t         hi,
    output logic [N-1:0] mask,
    output rcnt_t        cnt
);
    always_comb begin
        for (int i = 0; i < N; i++)
            mask[i] = (lo <= hi) ? (rid_t'(i) >= lo && rid_t'(i) < hi)
                                 : (rid_t'(i) >= lo || rid_t'(i) < hi);
    end
    assign cnt = {1'b0, rid_t'(hi - lo)};
endmodule

// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl: registered in-order ROB allocator with commit retirement and flush rollback
module rob_alloc_ctrl
    import nvio3_rob_pkg::*;
#(
    parameter int QENTRIES = QENTRIES_DEF,
    parameter int RENTRIES = RENTRIES_DEF,
    parameter int ASLOTS   = 2,
    parameter int CSLOTS   = 2,
    localparam int AW      = $clog2(ASLOTS + 1),
    localparam int CW      = $clog2(CSLOTS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [QENTRIES-1:0][QBW-1:0]  heads,
    input  logic [QENTRIES-1:0][2:0]      iq_state,
    input  logic                          alloc_en,
    input  logic [CW-1:0]                 cmt_cnt,
    input  logic                          flush,
    input  rid_t                          flush_rid,
    output logic [AW-1:0]                 rqueuedCnt,
    output logic [QENTRIES-1:0]           rqueuedOn,
    output rid_t [QENTRIES-1:0]           iq_rid_o,
    output rid_t                          rob_tail,
    output rid_t                          rob_head,
    output logic [RENTRIES-1:0]           rob_v,
    output rcnt_t                         rob_free,
    output logic                          rob_full
);
    logic [QENTRIES:0]   go;
    rid_t                flush_tail, tail_n, head_n;
    logic [RENTRIES-1:0] kill_m, cmt_m, grant_m, v_n;
    rcnt_t               kill_n, kill_eff, live_pre, free_n;
    logic                over;

    // grant n requires every older head to have been granted, so slot index equals n
    assign go[0] = alloc_en && !flush && !rst;
    for (genvar n = 0; n < QENTRIES; n++) begin : g_walk
        assign go[n+1] = go[n] && (iq_state[heads[n]] == IQS_QUEUE) && (n < ASLOTS)
                         && (rcnt_t'(n) < rob_free);
    end

    assign flush_tail = rid_add(flush_rid, 1);

    rob_range_mask #(.N(RENTRIES)) u_kill (
        .lo   (flush_tail),
        .hi   (rob_tail),
        .mask (kill_m),
        .cnt  (kill_n)
    );

    always_comb begin
        rqueuedOn  = '0;
        iq_rid_o   = '0;
        rqueuedCnt = '0;
        grant_m    = '0;
        cmt_m      = '0;
        for (int n = 0; n < QENTRIES; n++)
            if (go[n+1]) begin
                rqueuedOn[heads[n]] = 1'b1;
                iq_rid_o[heads[n]]  = rid_add(rob_tail, n);
                rqueuedCnt          = AW'(n + 1);
            end
        for (int i = 0; i < ASLOTS; i++)
            if (AW'(i) < rqueuedCnt) grant_m[rid_add(rob_tail, i)] = 1'b1;
        for (int i = 0; i < CSLOTS; i++)
            if (CW'(i) < cmt_cnt) cmt_m[rid_add(rob_head, i)] = 1'b1;
    end

    // over-commit collapses the ring to empty at the new tail
    always_comb begin
        kill_eff = flush ? kill_n : '0;
        live_pre = rcnt_t'(RENTRIES) - rob_free - kill_eff;
        over     = rcnt_t'(cmt_cnt) > live_pre;
        tail_n   = flush ? flush_tail : rid_add(rob_tail, int'(rqueuedCnt));
        head_n   = over ? tail_n : rid_add(rob_head, int'(cmt_cnt));
        free_n   = over ? rcnt_t'(RENTRIES)
                        : rob_free - rcnt_t'(rqueuedCnt) + rcnt_t'(cmt_cnt) + kill_eff;
        v_n      = over ? '0 : (rob_v & ~cmt_m & ~(flush ? kill_m : '0)) | grant_m;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rob_tail <= '0;
            rob_head <= '0;
            rob_v    <= '0;
            rob_free <= rcnt_t'(RENTRIES);
            rob_full <= 1'b0;
        end else begin
            assert (!over);
            rob_tail <= tail_n;
            rob_head <= head_n;
            rob_v    <= v_n;
            rob_free <= free_n;
            rob_full <= (free_n == '0);
        end
    end
endmodule
